ov7670_cfg_seq: RTL and testbench
=================================

OV7670_CFG_SEQ -- requirements
Module: ov7670_cfg_seq

Interface
REQ-001 SHALL have parameter c_nb_regs, default 4: number of register/value pairs in the configuration ROM, minimum 2.
REQ-002 SHALL have parameter c_ncams, default 3: number of cameras configured in turn through one SCCB master.
REQ-003 SHALL have parameter c_delay_endcnt, default 100000: settling delay in clk cycles after the soft-reset write (1 ms at 10 ns clk).
REQ-004 SHALL have parameter c_id, default 7'h21: 7-bit OV7670 slave id (write address 0x42).
REQ-005 clk  in  1  system clock; all logic on its rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 start  in  1  one-cycle pulse; begin full configuration of all cameras.
REQ-008 sccb_ready  in  1  SCCB master idle and able to accept start_tx.
REQ-009 finish_tx  in  1  SCCB master one-cycle pulse; current write completed.
REQ-010 start_tx  out  1  one-cycle request to the SCCB master.
REQ-011 id  out  7  slave id, constant c_id.
REQ-012 addr  out  8  OV7670 register address of the current write.
REQ-013 data_wr  out  8  value of the current write.
REQ-014 cam_sel  out  2  camera whose SCCB lines are muxed to the master.
REQ-015 busy  out  1  configuration in progress.
REQ-016 done  out  1  all cameras configured; held until next start.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE, WAIT_FIN, DELAY, NEXT_CAM, DONE.
REQ-018 IDLE/DONE: start=1 -> ISSUE, idx=0, cam_sel=0, done cleared next cycle; start ignored in all other states.
REQ-019 ISSUE: when sccb_ready=1, start_tx=1 for exactly that cycle, then WAIT_FIN; sccb_ready=0 -> stay, start_tx=0.
REQ-020 addr/data_wr SHALL be registered from ROM entry idx and stable from the start_tx cycle until finish_tx is seen.
REQ-021 WAIT_FIN on finish_tx: idx=0 -> DELAY; idx=c_nb_regs-1 -> NEXT_CAM; otherwise idx+1 and ISSUE.
REQ-022 DELAY SHALL last exactly c_delay_endcnt cycles, then idx=1 and ISSUE.
REQ-023 NEXT_CAM: cam_sel=c_ncams-1 -> DONE; otherwise cam_sel+1, idx=0, ISSUE.
REQ-024 cam_sel SHALL change only in NEXT_CAM or on start, never between start_tx and finish_tx.
REQ-025 ROM entry 0 SHALL be addr 0x12, data 0x80 (COM7 soft reset); remaining entries are the frame configuration.
REQ-026 finish_tx outside WAIT_FIN SHALL be ignored.
REQ-027 busy=1 in ISSUE, WAIT_FIN, DELAY, NEXT_CAM; done=1 only in DONE.
REQ-028 Delay counter width SHALL be the minimum bits to hold c_delay_endcnt-1.

Reset
REQ-029 On rst: state IDLE, start_tx=0, busy=0, done=0, cam_sel=0, idx=0, addr=0, data_wr=0, delay counter=0.
REQ-030 rst mid-transfer SHALL abort immediately with no further start_tx; a later start restarts from camera 0, entry 0.

Structure
REQ-031 Shared package SHALL hold the OV7670 register-address constants, COM7 soft-reset value, and c_id.
REQ-032 ROM SHALL be sub-module ov7670_cfg_rom: combinational idx -> {addr, data}.

Verification
REQ-033 rst, then start with c_nb_regs=4, c_ncams=3, c_delay_endcnt=16, instant-ready master model -> 12 start_tx pulses, cam_sel 0,0,0,0,1,...,2, then done=1.
REQ-034 After finish_tx of entry 0 -> exactly 16 cycles with start_tx=0 before the entry-1 start_tx.
REQ-035 sccb_ready held 0 for 50 cycles in ISSUE -> no start_tx; start_tx one cycle after sccb_ready rises, addr/data unchanged.
REQ-036 start pulses while busy and spurious finish_tx in ISSUE -> no change in idx, cam_sel, or pulse count.
REQ-037 rst asserted during camera 1 WAIT_FIN -> all outputs at reset values same cycle; new start -> first write 0x12/0x80 on cam_sel=0.
REQ-038 In DONE, start -> done=0, busy=1, full sequence repeats identically.

Source files
------------

// File: rtl/ov7670_cfg_seq_pkg.sv
// Shared OV7670 constants, sequencer state encoding and the configuration table.
package ov7670_cfg_seq_pkg;

    // 7-bit SCCB slave id of the OV7670 (0x42 write / 0x43 read)
    localparam logic [6:0] OV_ID = 7'h21;

    // OV7670 register addresses used by the configuration table
    localparam logic [7:0] REG_CLKRC = 8'h11;
    localparam logic [7:0] REG_COM7  = 8'h12;
    localparam logic [7:0] REG_COM15 = 8'h40;
    localparam logic [7:0] REG_TSLB  = 8'h3A;
    localparam logic [7:0] REG_COM3  = 8'h0C;
    localparam logic [7:0] REG_COM14 = 8'h3E;
    localparam logic [7:0] REG_MVFP  = 8'h1E;

    // COM7 value that soft-resets all sensor registers
    localparam logic [7:0] COM7_RESET = 8'h80;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_FIN,
        ST_DELAY,
        ST_NEXT_CAM,
        ST_DONE
    } cfg_state_t;

    // Entry 0 must stay the soft reset: the sequencer inserts the settling
    // delay after it. Indices past the table return 0xFF/0xFF, the usual
    // end-of-list marker in OV7670 init tables.
    function automatic logic [15:0] cfg_entry(input logic [7:0] i);
        case (i)
            8'd0:    cfg_entry = {REG_COM7,  COM7_RESET};
            8'd1:    cfg_entry = {REG_COM7,  8'h04};     // RGB output
            8'd2:    cfg_entry = {REG_COM15, 8'hD0};     // RGB565, full range
            8'd3:    cfg_entry = {REG_CLKRC, 8'h01};     // pclk = xclk / 2
            8'd4:    cfg_entry = {REG_TSLB,  8'h04};
            8'd5:    cfg_entry = {REG_COM3,  8'h00};
            8'd6:    cfg_entry = {REG_COM14, 8'h00};
            8'd7:    cfg_entry = {REG_MVFP,  8'h07};
            default: cfg_entry = 16'hFFFF;
        endcase
    endfunction

endpackage

// File: rtl/ov7670_cfg_seq_if.sv
// Request/completion signals between the config sequencer and the SCCB master.
interface ov7670_cfg_seq_if;
    logic       start_tx;
    logic [6:0] id;
    logic [7:0] addr;
    logic [7:0] data_wr;
    logic       sccb_ready;
    logic       finish_tx;

    // master: the sequencer issuing writes; slave: the SCCB engine serving them
    modport master (output start_tx, id, addr, data_wr, input sccb_ready, finish_tx);
    modport slave  (input start_tx, id, addr, data_wr, output sccb_ready, finish_tx);
endinterface

// File: rtl/ov7670_cfg_seq_rom.sv
// Combinational configuration ROM: idx -> {register address, value}.
module ov7670_cfg_rom
    import ov7670_cfg_seq_pkg::*;
#(
    parameter int c_idx_w = 2
) (
    input  logic [c_idx_w-1:0] idx,
    output logic [7:0]         addr,
    output logic [7:0]         data
);

    // Table lives in the package so other blocks can share it
    always_comb begin
        {addr, data} = cfg_entry(8'(idx));
    end

endmodule

// File: rtl/ov7670_cfg_seq.sv
// Writes the configuration ROM into each camera in turn through one SCCB
// master, pausing after the soft-reset write so the sensor can settle.
module ov7670_cfg_seq
    import ov7670_cfg_seq_pkg::*;
#(
    parameter int         c_nb_regs      = 4,
    parameter int         c_ncams        = 3,
    parameter int         c_delay_endcnt = 100000,
    parameter logic [6:0] c_id           = OV_ID
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    ov7670_cfg_seq_if.master    bus,
    output logic [1:0]          cam_sel,
    output logic                busy,
    output logic                done
);

    localparam int IW = (c_nb_regs > 1) ? $clog2(c_nb_regs) : 1;
    localparam int DW = (c_delay_endcnt > 1) ? $clog2(c_delay_endcnt) : 1;

    localparam logic [IW-1:0] LAST_IDX = IW'(c_nb_regs - 1);
    localparam logic [DW-1:0] DLY_LAST = DW'(c_delay_endcnt - 1);
    localparam logic [1:0]    LAST_CAM = 2'(c_ncams - 1);

    cfg_state_t    state;
    logic [IW-1:0] idx;
    logic [DW-1:0] dly_cnt;
    logic          start_tx;
    logic [7:0]    addr;
    logic [7:0]    data_wr;
    logic [7:0]    rom_addr;
    logic [7:0]    rom_data;

    ov7670_cfg_rom #(.c_idx_w(IW)) u_rom (
        .idx  (idx),
        .addr (rom_addr),
        .data (rom_data)
    );

    assign bus.start_tx = start_tx;
    assign bus.id       = c_id;
    assign bus.addr     = addr;
    assign bus.data_wr  = data_wr;

    // Sequencer FSM; every output is a register updated here
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            idx      <= '0;
            dly_cnt  <= '0;
            start_tx <= 1'b0;
            addr     <= '0;
            data_wr  <= '0;
            cam_sel  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            start_tx <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state   <= ST_ISSUE;
                        idx     <= '0;
                        cam_sel <= '0;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    // idx is frozen here, so addr/data settle before start_tx
                    // and hold through the whole transfer
                    addr    <= rom_addr;
                    data_wr <= rom_data;
                    if (bus.sccb_ready) begin
                        start_tx <= 1'b1;
                        state    <= ST_WAIT_FIN;
                    end
                end
                ST_WAIT_FIN: begin
                    if (bus.finish_tx) begin
                        if (idx == '0) begin
                            dly_cnt <= '0;
                            state   <= ST_DELAY;
                        end else if (idx == LAST_IDX) begin
                            state <= ST_NEXT_CAM;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= ST_ISSUE;
                        end
                    end
                end
                ST_DELAY: begin
                    if (dly_cnt == DLY_LAST) begin
                        dly_cnt <= '0;
                        idx     <= IW'(1);
                        state   <= ST_ISSUE;
                    end else begin
                        dly_cnt <= dly_cnt + 1'b1;
                    end
                end
                ST_NEXT_CAM: begin
                    if (cam_sel == LAST_CAM) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        cam_sel <= cam_sel + 1'b1;
                        idx     <= '0;
                        state   <= ST_ISSUE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ov7670_cfg_seq.sv
// Directed bench for ov7670_cfg_seq with a small SCCB master model.
module tb_ov7670_cfg_seq;

    localparam int NB  = 4;
    localparam int NC  = 3;
    localparam int DLY = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [1:0] cam_sel;
    logic       busy;
    logic       done;

    logic ready_en  = 1'b1;
    logic model_fin = 1'b0;
    logic spur_fin  = 1'b0;
    logic fin_pend  = 1'b0;

    int pass_cnt = 0;
    int total    = 0;
    int n_tx     = 0;
    int cyc      = 0;

    logic [1:0] log_cam  [256];
    logic [7:0] log_addr [256];
    logic [7:0] log_data [256];
    int         log_cyc  [256];

    logic [7:0] exp_addr [NB] = '{8'h12, 8'h12, 8'h40, 8'h11};
    logic [7:0] exp_data [NB] = '{8'h80, 8'h04, 8'hD0, 8'h01};

    ov7670_cfg_seq_if bif ();

    assign bif.sccb_ready = ready_en;
    assign bif.finish_tx  = model_fin | spur_fin;

    ov7670_cfg_seq #(
        .c_nb_regs      (NB),
        .c_ncams        (NC),
        .c_delay_endcnt (DLY)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .bus     (bif.master),
        .cam_sel (cam_sel),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    // Master model: finish_tx one cycle after each start_tx; logs every request
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            fin_pend  = 1'b0;
            model_fin = 1'b0;
        end else begin
            model_fin = fin_pend;
            fin_pend  = 1'b0;
            if (bif.start_tx) begin
                if (n_tx < 256) begin
                    log_cam[n_tx]  = cam_sel;
                    log_addr[n_tx] = bif.addr;
                    log_data[n_tx] = bif.data_wr;
                    log_cyc[n_tx]  = cyc;
                end
                n_tx     = n_tx + 1;
                fin_pend = 1'b1;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        total++; if (bif.start_tx !== 1'b0) $display("FAIL rst_start_tx got %b want 0", bif.start_tx); else pass_cnt++;
        total++; if (busy !== 1'b0)         $display("FAIL rst_busy got %b want 0", busy); else pass_cnt++;
        total++; if (done !== 1'b0)         $display("FAIL rst_done got %b want 0", done); else pass_cnt++;
        total++; if (cam_sel !== 2'd0)      $display("FAIL rst_cam_sel got %0d want 0", cam_sel); else pass_cnt++;
        total++; if (bif.addr !== 8'h00)    $display("FAIL rst_addr got %h want 00", bif.addr); else pass_cnt++;
        total++; if (bif.data_wr !== 8'h00) $display("FAIL rst_data got %h want 00", bif.data_wr); else pass_cnt++;
        total++; if (bif.id !== 7'h21)      $display("FAIL rst_id got %h want 21", bif.id); else pass_cnt++;
        rst = 1'b0;
        tick();
    endtask

    // Full run: 12 writes, cam 0,0,0,0,1,..,2, settle delay after each soft reset
    task automatic test_full_seq(input string tag);
        int base;
        int k;
        base = n_tx;
        pulse_start();
        total++; if (busy !== 1'b1 || done !== 1'b0) $display("FAIL %s_start_flags busy=%b done=%b want 1/0", tag, busy, done); else pass_cnt++;
        for (k = 0; k < 600; k++) begin
            if (done === 1'b1) break;
            tick();
        end
        total++; if (done !== 1'b1) $display("FAIL %s_done_timeout done=%b want 1", tag, done); else pass_cnt++;
        total++; if (busy !== 1'b0) $display("FAIL %s_busy_end got %b want 0", tag, busy); else pass_cnt++;
        total++; if (n_tx - base !== NB * NC) $display("FAIL %s_tx_count got %0d want %0d", tag, n_tx - base, NB * NC); else pass_cnt++;
        for (int i = 0; i < NB * NC; i++) begin
            total++;
            if (log_cam[base+i] !== 2'(i / NB) || log_addr[base+i] !== exp_addr[i % NB] || log_data[base+i] !== exp_data[i % NB])
                $display("FAIL %s_write%0d got cam%0d %h/%h want cam%0d %h/%h", tag, i, log_cam[base+i],
                         log_addr[base+i], log_data[base+i], i / NB, exp_addr[i % NB], exp_data[i % NB]);
            else pass_cnt++;
        end
        // finish_tx lands one cycle after start_tx; then DLY settle cycles and
        // one ISSUE cycle precede the next request
        total++; if (log_cyc[base+1] - log_cyc[base] !== DLY + 3)
            $display("FAIL %s_delay_gap got %0d want %0d", tag, log_cyc[base+1] - log_cyc[base], DLY + 3); else pass_cnt++;
        total++; if (log_cyc[base+2] - log_cyc[base+1] !== 3)
            $display("FAIL %s_plain_gap got %0d want 3", tag, log_cyc[base+2] - log_cyc[base+1]); else pass_cnt++;
    endtask

    task automatic test_ready_stall();
        int base;
        int k;
        ready_en = 1'b0;
        base = n_tx;
        pulse_start();
        repeat (50) tick();
        total++; if (n_tx !== base) $display("FAIL stall_no_tx got %0d want %0d", n_tx, base); else pass_cnt++;
        total++; if (busy !== 1'b1 || cam_sel !== 2'd0) $display("FAIL stall_state busy=%b cam=%0d want 1/0", busy, cam_sel); else pass_cnt++;
        total++; if (bif.addr !== 8'h12 || bif.data_wr !== 8'h80) $display("FAIL stall_addr got %h/%h want 12/80", bif.addr, bif.data_wr); else pass_cnt++;
        ready_en = 1'b1;
        tick();
        total++; if (bif.start_tx !== 1'b1) $display("FAIL stall_release start_tx=%b want 1", bif.start_tx); else pass_cnt++;
        total++; if (bif.addr !== 8'h12 || bif.data_wr !== 8'h80) $display("FAIL stall_release_addr got %h/%h want 12/80", bif.addr, bif.data_wr); else pass_cnt++;
        for (k = 0; k < 600; k++) begin
            if (done === 1'b1) break;
            tick();
        end
        total++; if (done !== 1'b1 || n_tx - base !== NB * NC) $display("FAIL stall_finish done=%b tx=%0d want 1/%0d", done, n_tx - base, NB * NC); else pass_cnt++;
    endtask

    // Start pulses while busy and a stray finish_tx in ISSUE must change nothing
    task automatic test_ignore();
        int base;
        int k;
        ready_en = 1'b0;
        base = n_tx;
        pulse_start();
        repeat (3) tick();
        start = 1'b1; spur_fin = 1'b1;
        tick();
        start = 1'b0; spur_fin = 1'b0;
        repeat (2) tick();
        total++; if (n_tx !== base || cam_sel !== 2'd0 || bif.addr !== 8'h12 || bif.data_wr !== 8'h80)
            $display("FAIL ignore_issue got tx=%0d cam=%0d %h/%h want %0d/0 12/80", n_tx - base, cam_sel, bif.addr, bif.data_wr, 0);
        else pass_cnt++;
        ready_en = 1'b1;
        for (k = 0; k < 600; k++) begin
            if (done === 1'b1) break;
            start = (k % 5 == 0);
            tick();
        end
        start = 1'b0;
        total++; if (done !== 1'b1 || n_tx - base !== NB * NC) $display("FAIL ignore_count done=%b tx=%0d want 1/%0d", done, n_tx - base, NB * NC); else pass_cnt++;
        for (int i = 0; i < NB * NC; i++) begin
            total++;
            if (log_cam[base+i] !== 2'(i / NB) || log_addr[base+i] !== exp_addr[i % NB] || log_data[base+i] !== exp_data[i % NB])
                $display("FAIL ignore_write%0d got cam%0d %h/%h want cam%0d %h/%h", i, log_cam[base+i],
                         log_addr[base+i], log_data[base+i], i / NB, exp_addr[i % NB], exp_data[i % NB]);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid();
        int base;
        int k;
        base = n_tx;
        pulse_start();
        for (k = 0; k < 400; k++) begin
            if (n_tx >= base + NB + 1) break;
            tick();
        end
        total++; if (n_tx !== base + NB + 1 || cam_sel !== 2'd1)
            $display("FAIL midrst_reach got tx=%0d cam=%0d want %0d/1", n_tx - base, cam_sel, NB + 1); else pass_cnt++;
        rst = 1'b1;
        #1;
        total++; if (bif.start_tx !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
            $display("FAIL midrst_flags got %b%b%b want 000", bif.start_tx, busy, done); else pass_cnt++;
        total++; if (cam_sel !== 2'd0 || bif.addr !== 8'h00 || bif.data_wr !== 8'h00)
            $display("FAIL midrst_regs got cam=%0d %h/%h want 0 00/00", cam_sel, bif.addr, bif.data_wr); else pass_cnt++;
        base = n_tx;
        repeat (5) tick();
        rst = 1'b0;
        repeat (5) tick();
        total++; if (n_tx !== base) $display("FAIL midrst_quiet got %0d want %0d", n_tx, base); else pass_cnt++;
        pulse_start();
        for (k = 0; k < 50; k++) begin
            if (n_tx > base) break;
            tick();
        end
        total++; if (n_tx !== base + 1 || log_cam[base] !== 2'd0 || log_addr[base] !== 8'h12 || log_data[base] !== 8'h80)
            $display("FAIL midrst_restart got tx=%0d cam%0d %h/%h want 1 cam0 12/80", n_tx - base, log_cam[base], log_addr[base], log_data[base]);
        else pass_cnt++;
        for (k = 0; k < 600; k++) begin
            if (done === 1'b1) break;
            tick();
        end
        total++; if (done !== 1'b1 || n_tx - base !== NB * NC) $display("FAIL midrst_finish done=%b tx=%0d want 1/%0d", done, n_tx - base, NB * NC); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_full_seq("full");
        test_full_seq("again");
        test_ready_stall();
        test_ignore();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
